// File: rtl/regfile_writeback_arbiter.sv
// Register-file write-back arbiter.
// Four write-back sources (ALU, memory, immediate, link) compete for the
// single register-file write port. A round-robin pointer picks one winner
// per cycle. Every output is registered, so a request sampled on one edge
// shows up as a grant during the following cycle. Hold freezes
// arbitration. Writes to register 0 are granted but not enabled. WrCount
// tallies the writes that were actually committed.

module regfile_writeback_arbiter (
    input  logic        CLK,
    input  logic        Reset_n,
    input  logic [3:0]  Req,
    input  logic [3:0]  Dst0,
    input  logic [3:0]  Dst1,
    input  logic [3:0]  Dst2,
    input  logic [3:0]  Dst3,
    input  logic        Hold,
    output logic [1:0]  RFWD,
    output logic        RFWE,
    output logic [3:0]  RFWA,
    output logic [3:0]  Grant,
    output logic [15:0] WrCount
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WRITE  = 2'd1,
        FROZEN = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [1:0]  ptr_q, ptr_d;
    logic [3:0]  grant_q, grant_d;
    logic [1:0]  rfwd_q, rfwd_d;
    logic [3:0]  rfwa_q, rfwa_d;
    logic        rfwe_q, rfwe_d;
    logic [15:0] wrCount_q, wrCount_d;

    logic        winnerFound;
    logic [1:0]  winnerIdx;
    logic [1:0]  candIdx;
    logic [3:0]  winnerDst;

    // Round-robin search: start one past the last winner and wrap.
    // The last winner itself is checked last, so it has the lowest priority.
    always_comb begin
        winnerFound = 1'b0;
        winnerIdx   = ptr_q;
        candIdx     = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            candIdx = ptr_q + k[1:0];
            if (!winnerFound && Req[candIdx]) begin
                winnerFound = 1'b1;
                winnerIdx   = candIdx;
            end
        end
    end

    // Pick the destination register that belongs to the winning source.
    always_comb begin
        winnerDst = Dst0;
        case (winnerIdx)
            2'd0:    winnerDst = Dst0;
            2'd1:    winnerDst = Dst1;
            2'd2:    winnerDst = Dst2;
            default: winnerDst = Dst3;
        endcase
    end

    // Next-state and registered-output logic.
    // Hold overrides everything. Leaving FROZEN always takes one idle
    // cycle before any grant. A grant captures the winner's select and
    // address. The counter picks up the write that is committed this cycle.
    always_comb begin
        state_d   = IDLE;
        ptr_d     = ptr_q;
        grant_d   = 4'b0000;
        rfwd_d    = rfwd_q;
        rfwa_d    = rfwa_q;
        rfwe_d    = 1'b0;
        wrCount_d = wrCount_q + {15'd0, rfwe_q};

        if (Hold) begin
            state_d = FROZEN;
        end else if (state_q == FROZEN) begin
            state_d = IDLE;
        end else if (winnerFound) begin
            state_d = WRITE;
            ptr_d   = winnerIdx;
            grant_d = 4'b0001 << winnerIdx;
            rfwd_d  = winnerIdx;
            rfwa_d  = winnerDst;
            rfwe_d  = (winnerDst != 4'd0);
        end else begin
            state_d = IDLE;
        end
    end

    // State and output registers.
    // Reset clears everything asynchronously. Ptr is cleared to 3 so that
    // source 0 wins first.
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= IDLE;
            ptr_q     <= 2'd3;
            grant_q   <= 4'b0000;
            rfwd_q    <= 2'd0;
            rfwa_q    <= 4'd0;
            rfwe_q    <= 1'b0;
            wrCount_q <= 16'd0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            grant_q   <= grant_d;
            rfwd_q    <= rfwd_d;
            rfwa_q    <= rfwa_d;
            rfwe_q    <= rfwe_d;
            wrCount_q <= wrCount_d;
        end
    end

    assign Grant   = grant_q;
    assign RFWD    = rfwd_q;
    assign RFWA    = rfwa_q;
    assign RFWE    = rfwe_q;
    assign WrCount = wrCount_q;

endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
// Directed testbench for regfile_writeback_arbiter.
// The expected values below were worked out by hand.

module tb_regfile_writeback_arbiter;

    logic        CLK;
    logic        Reset_n;
    logic [3:0]  Req;
    logic [3:0]  Dst0, Dst1, Dst2, Dst3;
    logic        Hold;
    logic [1:0]  RFWD;
    logic        RFWE;
    logic [3:0]  RFWA;
    logic [3:0]  Grant;
    logic [15:0] WrCount;

    int checkCount;
    int failCount;

    regfile_writeback_arbiter dut (
        .CLK     (CLK),
        .Reset_n (Reset_n),
        .Req     (Req),
        .Dst0    (Dst0),
        .Dst1    (Dst1),
        .Dst2    (Dst2),
        .Dst3    (Dst3),
        .Hold    (Hold),
        .RFWD    (RFWD),
        .RFWE    (RFWE),
        .RFWA    (RFWA),
        .Grant   (Grant),
        .WrCount (WrCount)
    );

    // Free-running clock with a 10 ns period.
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Count one comparison and report it if it does not match.
    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drive the request vector and hold input.
    task automatic applyStimulus(input logic [3:0] reqV, input logic holdV);
        Req  = reqV;
        Hold = holdV;
    endtask

    // Wait for a rising edge, then settle just past it before sampling.
    task automatic stepCycle();
        @(posedge CLK);
        #1;
    endtask

    // Pulse reset low between clock edges and leave the inputs quiet.
    task automatic doReset();
        applyStimulus(4'b0000, 1'b0);
        @(negedge CLK);
        Reset_n = 1'b0;
        #2;
        Reset_n = 1'b1;
        #1;
    endtask

    initial begin
        checkCount = 0;
        failCount  = 0;
        Reset_n    = 1'b1;
        Req        = 4'b0000;
        Hold       = 1'b0;
        Dst0 = 4'd0; Dst1 = 4'd0; Dst2 = 4'd0; Dst3 = 4'd0;

        // Check the reset state.
        #3;
        Reset_n = 1'b0;
        #4;
        checkOutput("rst_grant", {12'd0, Grant}, 16'h0);
        checkOutput("rst_rfwe", {15'd0, RFWE}, 16'h0);
        checkOutput("rst_rfwd", {14'd0, RFWD}, 16'h0);
        checkOutput("rst_rfwa", {12'd0, RFWA}, 16'h0);
        checkOutput("rst_wrcount", WrCount, 16'h0);
        Reset_n = 1'b1;

        // Single write to r5 from source 0.
        doReset();
        Dst0 = 4'd5;
        applyStimulus(4'b0001, 1'b0);
        stepCycle();
        checkOutput("single_grant", {12'd0, Grant}, 16'h1);
        checkOutput("single_rfwd", {14'd0, RFWD}, 16'h0);
        checkOutput("single_rfwa", {12'd0, RFWA}, 16'h5);
        checkOutput("single_rfwe", {15'd0, RFWE}, 16'h1);
        applyStimulus(4'b0000, 1'b0);
        stepCycle();
        checkOutput("single_wrcount", WrCount, 16'd1);
        checkOutput("single_idle_grant", {12'd0, Grant}, 16'h0);
        checkOutput("single_idle_rfwa_hold", {12'd0, RFWA}, 16'h5);

        // All four sources request continuously, so grants rotate.
        doReset();
        Dst0 = 4'd1; Dst1 = 4'd2; Dst2 = 4'd3; Dst3 = 4'd4;
        applyStimulus(4'b1111, 1'b0);
        for (int k = 0; k < 8; k++) begin
            stepCycle();
            checkOutput($sformatf("rr_grant_%0d", k), {12'd0, Grant}, 16'(4'b0001 << (k % 4)));
            checkOutput($sformatf("rr_rfwd_%0d", k), {14'd0, RFWD}, 16'(k % 4));
            checkOutput($sformatf("rr_rfwa_%0d", k), {12'd0, RFWA}, 16'((k % 4) + 1));
        end
        applyStimulus(4'b0000, 1'b0);
        stepCycle();
        checkOutput("rr_wrcount", WrCount, 16'd8);

        // A write to r0 is granted but not enabled, and it still moves Ptr.
        doReset();
        Dst0 = 4'd1; Dst1 = 4'd2; Dst2 = 4'd0; Dst3 = 4'd4;
        applyStimulus(4'b0100, 1'b0);
        stepCycle();
        checkOutput("r0_grant", {12'd0, Grant}, 16'h4);
        checkOutput("r0_rfwd", {14'd0, RFWD}, 16'h2);
        checkOutput("r0_rfwe", {15'd0, RFWE}, 16'h0);
        applyStimulus(4'b0000, 1'b0);
        stepCycle();
        checkOutput("r0_wrcount", WrCount, 16'd0);
        applyStimulus(4'b1111, 1'b0);
        stepCycle();
        checkOutput("r0_next_grant", {12'd0, Grant}, 16'h8);
        checkOutput("r0_next_rfwa", {12'd0, RFWA}, 16'h4);

        // While Hold is high nothing is granted; after release there is one idle cycle.
        doReset();
        Dst0 = 4'd3; Dst1 = 4'd6;
        applyStimulus(4'b0011, 1'b1);
        for (int k = 0; k < 3; k++) begin
            stepCycle();
            checkOutput($sformatf("hold_grant_%0d", k), {12'd0, Grant}, 16'h0);
            checkOutput($sformatf("hold_rfwe_%0d", k), {15'd0, RFWE}, 16'h0);
        end
        applyStimulus(4'b0011, 1'b0);
        stepCycle();
        checkOutput("unfreeze_idle_grant", {12'd0, Grant}, 16'h0);
        stepCycle();
        checkOutput("unfreeze_grant", {12'd0, Grant}, 16'h1);
        checkOutput("unfreeze_rfwa", {12'd0, RFWA}, 16'h3);

        // Hold rising during a write still commits that write.
        applyStimulus(4'b0011, 1'b1);
        stepCycle();
        checkOutput("holdrise_wrcount", WrCount, 16'd1);
        checkOutput("holdrise_grant", {12'd0, Grant}, 16'h0);
        applyStimulus(4'b0000, 1'b0);
        stepCycle();

        // Reset in the middle of a write aborts it immediately.
        doReset();
        Dst0 = 4'd7; Dst1 = 4'd8;
        applyStimulus(4'b0011, 1'b0);
        stepCycle();
        stepCycle();
        checkOutput("prerst_grant", {12'd0, Grant}, 16'h2);
        checkOutput("prerst_wrcount", WrCount, 16'd1);
        #2;
        Reset_n = 1'b0;
        #1;
        checkOutput("midrst_rfwe", {15'd0, RFWE}, 16'h0);
        checkOutput("midrst_grant", {12'd0, Grant}, 16'h0);
        checkOutput("midrst_wrcount", WrCount, 16'd0);
        @(negedge CLK);
        Reset_n = 1'b1;
        stepCycle();
        checkOutput("postrst_grant", {12'd0, Grant}, 16'h1);
        checkOutput("postrst_rfwa", {12'd0, RFWA}, 16'h7);

        // The write counter wraps from 0xFFFF back to 0.
        doReset();
        Dst0 = 4'd9;
        applyStimulus(4'b0001, 1'b0);
        repeat (65536) stepCycle();
        checkOutput("wrap_pre", WrCount, 16'hFFFF);
        checkOutput("wrap_pre_rfwe", {15'd0, RFWE}, 16'h1);
        applyStimulus(4'b0000, 1'b0);
        stepCycle();
        checkOutput("wrap_post", WrCount, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
